circle_arc: RTL and testbench
=============================

Name: circle_arc

Overview:
- Parametrised successor to the fixed-size Bresenham circle drawer.
- Draws a full circle or any subset of its eight octants, which gives the arc primitive the Reuleaux-triangle top level needs.
- Sits between the top-level drawing controller and the VGA adapter, and emits one candidate pixel per clock.
- Adds over the previous generation: parametrised widths and screen size, an octant mask, inputs latched at start, a busy/done pulse handshake, and an optional clip window.

Parameters:
X_W, 8, width of centre_x and vga_x
Y_W, 7, width of centre_y and vga_y
R_W, 8, width of radius
COLOUR_W, 3, width of colour and vga_colour
SCREEN_W, 160, number of visible columns; plot only when x < SCREEN_W
SCREEN_H, 120, number of visible rows; plot only when y < SCREEN_H

Ports:
clk  in  1  clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only in IDLE
colour  in  COLOUR_W  pixel colour; latched at accept
centre_x  in  X_W  centre column, unsigned; latched at accept
centre_y  in  Y_W  centre row, unsigned; latched at accept
radius  in  R_W  radius, unsigned; latched at accept
octant_mask  in  8  bit k enables octant k; latched at accept
busy  out  1  high from the cycle after accept through the DONE cycle
done  out  1  one-cycle pulse when drawing completes
vga_x  out  X_W  pixel column
vga_y  out  Y_W  pixel row
vga_colour  out  COLOUR_W  latched colour
vga_plot  out  1  write strobe for the current pixel

Behaviour:
- Reset: synchronous, active-high, and takes priority over everything, including mid-draw. On the following edge: state IDLE; busy, done, vga_plot, vga_x, vga_y, vga_colour all 0; internal registers cleared.
- States:
  - IDLE: if start=1 at edge T, latch all inputs; set x=radius, y=0, crit=1-radius, sub=0; go to DRAW.
  - DRAW: one candidate pixel per cycle, sub=0..7. At sub=7, step the iteration:
    - y' = y+1.
    - If crit <= 0: crit' = crit + 2y' + 1.
    - Else: x' = x-1 and crit' = crit + 2(y'-x') + 1.
    - If y' <= x', continue DRAW with sub=0; otherwise go to DONE.
  - DONE: done=1 and busy=1 for one cycle, then IDLE.
- Arithmetic: x, y and crit are signed, max(X_W,Y_W,R_W)+2 bits wide. Pixel positions are computed at the same width, then range-checked.
- Octant mapping for sub k (cx, cy are the latched centre):
  - 0: (cx+x, cy+y)
  - 1: (cx+y, cy+x)
  - 2: (cx-x, cy+y)
  - 3: (cx-y, cy+x)
  - 4: (cx-x, cy-y)
  - 5: (cx-y, cy-x)
  - 6: (cx+x, cy-y)
  - 7: (cx+y, cy-x)
- Outputs: vga_x and vga_y are the low X_W / Y_W bits of the computed position. They are combinational from registered state and valid in every DRAW cycle.
- vga_plot = DRAW and octant_mask[sub] and 0 <= px < SCREEN_W and 0 <= py < SCREEN_H. It is 0 in IDLE and DONE.
- Masked or off-screen octants still consume their cycle, so latency is independent of mask and position.
- Latency: with start accepted at edge T, pixel j appears in cycle T+1+j. done is high in cycle T+1+8N, where N is the iteration count.
- Duplicate pixels on axes and diagonals are not suppressed.
- start asserted while busy is ignored, not queued. Input changes after accept have no effect.
- start held high continuously begins a new draw on the IDLE cycle after DONE.

Optional Feature:
- Macro: CIRCLE_ARC_CLIP_EN.
- When defined:
  - Adds inputs clip_x0, clip_x1 (X_W bits) and clip_y0, clip_y1 (Y_W bits), all latched at accept.
  - vga_plot additionally requires clip_x0 <= px <= clip_x1 and clip_y0 <= py <= clip_y1.
  - An empty window (x0 > x1 or y0 > y1) plots nothing but keeps full latency.
- When undefined: the ports are absent and only the screen bounds apply.

Decomposition:
- Package circle_arc_pkg holds:
  - state enum {IDLE, DRAW, DONE};
  - the octant sign/swap table as a constant array indexed by sub;
  - default SCREEN_W/SCREEN_H constants.
- Sub-module circle_octant_map: purely combinational; takes (cx, cy, x, y, sub) and returns signed (px, py).
- The FSM and Bresenham stepper stay in circle_arc.

Test Plan:
- Reset, then start with r=4, c=(80,60), mask=FF: 32 DRAW cycles; first pixel (84,60); done high at T+33 only; busy high T+1..T+33.
- r=0, c=(10,10), mask=FF: 8 pixels, all (10,10) with plot=1; done at T+9. r=1: 16 pixels; done at T+17.
- r=4, c=(2,2), mask=FF: every pixel with px<0 or py<0 has vga_plot=0; cycle count is unchanged at 32.
- mask=8'b0000_0011, r=4, c=(80,60): vga_plot only when sub is 0 or 1; all other pixels have plot=0.
- start pulsed mid-draw, then rst at cycle T+10: the mid-draw start is ignored; one edge after rst, all outputs are 0 and state is IDLE; a new start is accepted normally.
- With CIRCLE_ARC_CLIP_EN defined, window x 80..90, y 55..65, r=4, c=(80,60): plotted pixels have px >= 80 only; with x0=91, x1=90, no pixel is plotted and done still arrives at T+33.

Source files
------------

// File: rtl/circle_arc_pkg.sv
// Shared types and constants for the circle_arc octant drawer.
// The octant table encodes, per sub-step, whether x/y swap and which offsets negate.
package circle_arc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic swap;
        logic neg_x;
        logic neg_y;
    } oct_t;

    // Index k gives the transform for octant k: (cx +/- dx, cy +/- dy), dx/dy = x/y or y/x.
    localparam oct_t [0:7] OCT_TABLE = {
        oct_t'{1'b0, 1'b0, 1'b0},
        oct_t'{1'b1, 1'b0, 1'b0},
        oct_t'{1'b0, 1'b1, 1'b0},
        oct_t'{1'b1, 1'b1, 1'b0},
        oct_t'{1'b0, 1'b1, 1'b1},
        oct_t'{1'b1, 1'b1, 1'b1},
        oct_t'{1'b0, 1'b0, 1'b1},
        oct_t'{1'b1, 1'b0, 1'b1}
    };

    localparam int SCREEN_W_DEFAULT = 160;
    localparam int SCREEN_H_DEFAULT = 120;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/circle_octant_map.sv
// Combinational octant mapper: turns a first-octant offset (x, y) into the
// signed screen position for octant sub around centre (cx, cy).
module circle_octant_map
    import circle_arc_pkg::*;
#(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 10
) (
    input  logic [X_W-1:0]        cx,
    input  logic [Y_W-1:0]        cy,
    input  logic signed [C_W-1:0] x,
    input  logic signed [C_W-1:0] y,
    input  logic [2:0]            sub,
    output logic signed [C_W-1:0] px,
    output logic signed [C_W-1:0] py
);

    oct_t                  oct;
    logic signed [C_W-1:0] cx_s;
    logic signed [C_W-1:0] cy_s;
    logic signed [C_W-1:0] dx;
    logic signed [C_W-1:0] dy;

    // NOTE: every variable is assigned on every path through the block, so no latch is inferred.
    always_comb begin
        oct  = OCT_TABLE[sub];
        cx_s = C_W'(cx);
        cy_s = C_W'(cy);
        dx   = oct.swap ? y : x;
        dy   = oct.swap ? x : y;
        px   = oct.neg_x ? (cx_s - dx) : (cx_s + dx);
        py   = oct.neg_y ? (cy_s - dy) : (cy_s + dy);
    end

endmodule

// File: rtl/circle_arc.sv
// Bresenham circle/arc drawer emitting one candidate pixel per clock, eight octants per step.
// Optional clip window enabled by defining CIRCLE_ARC_CLIP_EN.
module circle_arc
    import circle_arc_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [R_W-1:0]      radius,
    input  logic [7:0]          octant_mask,
`ifdef CIRCLE_ARC_CLIP_EN
    input  logic [X_W-1:0]      clip_x0,
    input  logic [X_W-1:0]      clip_x1,
    input  logic [Y_W-1:0]      clip_y0,
    input  logic [Y_W-1:0]      clip_y1,
`endif
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int C_W = max3(X_W, Y_W, R_W) + 2;

    state_t                state_q;
    state_t                state_d;
    logic signed [C_W-1:0] x_q;
    logic signed [C_W-1:0] y_q;
    logic signed [C_W-1:0] crit_q;
    logic [2:0]            sub_q;
    logic [X_W-1:0]        cx_q;
    logic [Y_W-1:0]        cy_q;
    logic [COLOUR_W-1:0]   colour_q;
    logic [7:0]            mask_q;
`ifdef CIRCLE_ARC_CLIP_EN
    logic [X_W-1:0]        clip_x0_q;
    logic [X_W-1:0]        clip_x1_q;
    logic [Y_W-1:0]        clip_y0_q;
    logic [Y_W-1:0]        clip_y1_q;
`endif

    logic signed [C_W-1:0] x_step;
    logic signed [C_W-1:0] y_step;
    logic signed [C_W-1:0] crit_step;
    logic                  step_more;
    logic signed [C_W-1:0] px;
    logic signed [C_W-1:0] py;
    logic signed [31:0]    px_ext;
    logic signed [31:0]    py_ext;
    logic                  on_screen;
    logic                  in_window;

    always_comb begin
        y_step = y_q + C_W'(1);
        x_step = x_q;
        if (crit_q <= 0) begin
            crit_step = crit_q + (y_step <<< 1) + C_W'(1);
        end else begin
            x_step    = x_q - C_W'(1);
            crit_step = crit_q + ((y_step - x_step) <<< 1) + C_W'(1);
        end
        step_more = (y_step <= x_step);
    end

    // NOTE: rst is sampled only on the clock edge and overrides every other transition, including mid-draw.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = DRAW;
            end
            DRAW: begin
                busy = 1'b1;
                if (sub_q == 3'd7) state_d = step_more ? DRAW : DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            crit_q    <= '0;
            sub_q     <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            colour_q  <= '0;
            mask_q    <= '0;
`ifdef CIRCLE_ARC_CLIP_EN
            clip_x0_q <= '0;
            clip_x1_q <= '0;
            clip_y0_q <= '0;
            clip_y1_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cx_q      <= centre_x;
                        cy_q      <= centre_y;
                        colour_q  <= colour;
                        mask_q    <= octant_mask;
`ifdef CIRCLE_ARC_CLIP_EN
                        clip_x0_q <= clip_x0;
                        clip_x1_q <= clip_x1;
                        clip_y0_q <= clip_y0;
                        clip_y1_q <= clip_y1;
`endif
                        x_q       <= C_W'(radius);
                        y_q       <= '0;
                        crit_q    <= C_W'(1) - C_W'(radius);
                        sub_q     <= '0;
                    end
                end
                DRAW: begin
                    sub_q <= sub_q + 3'd1;
                    if (sub_q == 3'd7) begin
                        x_q    <= x_step;
                        y_q    <= y_step;
                        crit_q <= crit_step;
                    end
                end
                default: ;
            endcase
        end
    end

    circle_octant_map #(
        .X_W (X_W),
        .Y_W (Y_W),
        .C_W (C_W)
    ) u_map (
        .cx  (cx_q),
        .cy  (cy_q),
        .x   (x_q),
        .y   (y_q),
        .sub (sub_q),
        .px  (px),
        .py  (py)
    );

    assign px_ext     = 32'(px);
    assign py_ext     = 32'(py);
    assign vga_x      = px[X_W-1:0];
    assign vga_y      = py[Y_W-1:0];
    assign vga_colour = colour_q;

    always_comb begin
        on_screen = (px_ext >= 0) && (px_ext < SCREEN_W) && (py_ext >= 0) && (py_ext < SCREEN_H);
        in_window = 1'b1;
`ifdef CIRCLE_ARC_CLIP_EN
        // An inverted window fails one bound for every pixel, so nothing plots.
        in_window = (px_ext >= $signed(32'(clip_x0_q))) && (px_ext <= $signed(32'(clip_x1_q)))
                 && (py_ext >= $signed(32'(clip_y0_q))) && (py_ext <= $signed(32'(clip_y1_q)));
`endif
        vga_plot = (state_q == DRAW) && mask_q[sub_q] && on_screen && in_window;
    end

endmodule

// File: tb/tb_circle_arc.sv
// Self-checking bench for circle_arc: directed and random draws against a queue-based model.
// Clip-window tests run only when CIRCLE_ARC_CLIP_EN is defined.
module tb_circle_arc;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int R_W = 8;
    localparam int COLOUR_W = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [COLOUR_W-1:0] colour;
    logic [X_W-1:0]      centre_x;
    logic [Y_W-1:0]      centre_y;
    logic [R_W-1:0]      radius;
    logic [7:0]          octant_mask;
    logic [X_W-1:0]      clip_x0 = '0;
    logic [X_W-1:0]      clip_x1 = '1;
    logic [Y_W-1:0]      clip_y0 = '0;
    logic [Y_W-1:0]      clip_y1 = '1;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    int n_checks = 0;
    int n_errors = 0;
    int exp_x[$];
    int exp_y[$];
    int exp_p[$];

    always #5 clk = ~clk;

    circle_arc #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .R_W      (R_W),
        .COLOUR_W (COLOUR_W),
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .colour      (colour),
        .centre_x    (centre_x),
        .centre_y    (centre_y),
        .radius      (radius),
        .octant_mask (octant_mask),
`ifdef CIRCLE_ARC_CLIP_EN
        .clip_x0     (clip_x0),
        .clip_x1     (clip_x1),
        .clip_y0     (clip_y0),
        .clip_y1     (clip_y1),
`endif
        .busy        (busy),
        .done        (done),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: midpoint circle walk in plain integers, eight mirrored points per step.
    task automatic build_model(input int cx, input int cy, input int r, input logic [7:0] mask,
                               input int wx0, input int wx1, input int wy0, input int wy1);
        int x, y, d, px, py;
        bit p;
        exp_x.delete();
        exp_y.delete();
        exp_p.delete();
        x = r;
        y = 0;
        d = 1 - r;
        do begin
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: begin px = cx + x; py = cy + y; end
                    1: begin px = cx + y; py = cy + x; end
                    2: begin px = cx - x; py = cy + y; end
                    3: begin px = cx - y; py = cy + x; end
                    4: begin px = cx - x; py = cy - y; end
                    5: begin px = cx - y; py = cy - x; end
                    6: begin px = cx + x; py = cy - y; end
                    default: begin px = cx + y; py = cy - x; end
                endcase
                p = mask[k] && px >= 0 && px < 160 && py >= 0 && py < 120;
`ifdef CIRCLE_ARC_CLIP_EN
                p = p && px >= wx0 && px <= wx1 && py >= wy0 && py <= wy1;
`endif
                exp_x.push_back(px & ((1 << X_W) - 1));
                exp_y.push_back(py & ((1 << Y_W) - 1));
                exp_p.push_back(int'(p));
            end
            y++;
            if (d <= 0) begin
                d += 2 * y + 1;
            end else begin
                x--;
                d += 2 * (y - x) + 1;
            end
        end while (y <= x);
    endtask

    task automatic run_draw(input string tag, input int cx, input int cy, input int r,
                            input logic [7:0] mask, input logic [2:0] col,
                            input bit scramble, input bit hold);
        int n;
        build_model(cx, cy, r, mask, int'(clip_x0), int'(clip_x1), int'(clip_y0), int'(clip_y1));
        n = exp_x.size();
        centre_x    = X_W'(cx);
        centre_y    = Y_W'(cy);
        radius      = R_W'(r);
        octant_mask = mask;
        colour      = col;
        start       = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".done"}, 32'(done), 32'd0);
            check({tag, ".x"}, 32'(vga_x), 32'(exp_x[j]));
            check({tag, ".y"}, 32'(vga_y), 32'(exp_y[j]));
            check({tag, ".plot"}, 32'(vga_plot), 32'(exp_p[j]));
            if (j == 0) check({tag, ".colour"}, 32'(vga_colour), 32'(col));
            if (scramble && j < n - 1) begin
                centre_x    = X_W'($urandom);
                centre_y    = Y_W'($urandom);
                radius      = R_W'($urandom);
                octant_mask = 8'($urandom);
                colour      = COLOUR_W'($urandom);
                start       = 1'($urandom);
            end
            if (j == n - 1) start = hold;
        end
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd1);
        check({tag, ".done_busy"}, 32'(busy), 32'd1);
        check({tag, ".done_plot"}, 32'(vga_plot), 32'd0);
        @(negedge clk);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".idle_done"}, 32'(done), 32'd0);
        check({tag, ".idle_plot"}, 32'(vga_plot), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        colour      = '0;
        centre_x    = '0;
        centre_y    = '0;
        radius      = '0;
        octant_mask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.plot", 32'(vga_plot), 32'd0);
        check("rst.x", 32'(vga_x), 32'd0);
        check("rst.y", 32'(vga_y), 32'd0);
        check("rst.colour", 32'(vga_colour), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_draw("r4", 80, 60, 4, 8'hFF, 3'd5, 1'b0, 1'b0);
        run_draw("r0", 10, 10, 0, 8'hFF, 3'd2, 1'b0, 1'b0);
        run_draw("r1", 10, 10, 1, 8'hFF, 3'd7, 1'b0, 1'b0);
        run_draw("corner", 2, 2, 4, 8'hFF, 3'd1, 1'b0, 1'b0);
        run_draw("mask03", 80, 60, 4, 8'b0000_0011, 3'd3, 1'b0, 1'b0);
        run_draw("latch", 100, 50, 9, 8'hA5, 3'd6, 1'b1, 1'b0);
        run_draw("hold_a", 150, 115, 12, 8'hFF, 3'd4, 1'b0, 1'b1);
        run_draw("hold_b", 150, 115, 12, 8'hFF, 3'd4, 1'b0, 1'b0);

        // Mid-draw start is ignored, then reset cuts the draw short at T+10.
        build_model(80, 60, 4, 8'hFF, int'(clip_x0), int'(clip_x1), int'(clip_y0), int'(clip_y1));
        centre_x    = 8'd80;
        centre_y    = 7'd60;
        radius      = 8'd4;
        octant_mask = 8'hFF;
        colour      = 3'd6;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            check("midstart.x", 32'(vga_x), 32'(exp_x[j]));
            check("midstart.y", 32'(vga_y), 32'(exp_y[j]));
            if (j == 2) start = 1'b1;
            if (j == 3) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.plot", 32'(vga_plot), 32'd0);
        check("midrst.x", 32'(vga_x), 32'd0);
        check("midrst.y", 32'(vga_y), 32'd0);
        check("midrst.colour", 32'(vga_colour), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst.idle_busy", 32'(busy), 32'd0);
        run_draw("after_rst", 40, 30, 6, 8'hFF, 3'd5, 1'b0, 1'b0);

`ifdef CIRCLE_ARC_CLIP_EN
        clip_x0 = 8'd80;
        clip_x1 = 8'd90;
        clip_y0 = 7'd55;
        clip_y1 = 7'd65;
        run_draw("clip", 80, 60, 4, 8'hFF, 3'd3, 1'b0, 1'b0);
        clip_x0 = 8'd91;
        clip_x1 = 8'd90;
        run_draw("clip_empty", 80, 60, 4, 8'hFF, 3'd3, 1'b0, 1'b0);
        clip_x0 = '0;
        clip_x1 = '1;
`endif

        for (int i = 0; i < 12; i++) begin
            run_draw("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 30)), 8'($urandom), 3'($urandom),
                     1'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
